nmea_rmc_parser: RTL
====================

Name: nmea_rmc_parser

Overview:
Parametrised successor to the GPRMC field extractor. Consumes the UART byte stream and accepts RMC sentences from talker GP, or GN when enabled. Captures UTC time, status, latitude and longitude into shadow registers, verifies the NMEA XOR checksum, and commits all outputs atomically with a one-cycle new_fix pulse. Sits between uart_rx and the display/formatting logic.

Parameters:
LAT_MAX, 10, max latitude characters captured (digits and '.')
LON_MAX, 11, max longitude characters captured
TIME_MAX, 10, max UTC time characters captured
ACCEPT_GN, 1, 1 = talker "GN" accepted in addition to "GP"
CHECK_CSUM, 1, 1 = commit only on checksum match; 0 = checksum characters consumed but not compared

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rx_data  in  8  received byte
rx_valid  in  1  byte strobe, one cycle per byte
lat_chars  out  8*LAT_MAX  latitude ASCII; char 0 in bits [7:0]
lat_len  out  $clog2(LAT_MAX+1)  valid latitude characters
lat_dir  out  1  1 = N, 0 = S
lon_chars  out  8*LON_MAX  longitude ASCII; char 0 in bits [7:0]
lon_len  out  $clog2(LON_MAX+1)  valid longitude characters
lon_dir  out  1  1 = E, 0 = W
utc_chars  out  8*TIME_MAX  UTC time ASCII
utc_len  out  $clog2(TIME_MAX+1)  valid time characters
fix_valid  out  1  1 = status field 'A', 0 = otherwise
new_fix  out  1  one-cycle pulse on commit
csum_err  out  1  one-cycle pulse when an RMC sentence is rejected (bad checksum, non-hex, overflow, short)

Behaviour:
- Reset (rst = 0, async): all outputs 0, all shadow registers 0, state IDLE.
- FSM states: IDLE, TALK1, TALK2, TYP_R, TYP_M, TYP_C, FIELDS, CS_HI, CS_LO. Advances only on rx_valid.
- IDLE: '$' -> TALK1; clear running XOR, field counter, indices and overflow flag.
- TALK1: 'G' -> TALK2. TALK2: 'P' -> TYP_R; 'N' -> TYP_R only if ACCEPT_GN = 1. TYP_R/M/C match 'R', 'M', 'C'; TYP_C -> FIELDS. Any mismatch -> IDLE, silently.
- '$' in any state other than IDLE restarts at TALK1 with XOR and counters cleared. A partial sentence never commits.
- Running XOR covers every byte after '$' up to, but excluding, '*'. Header bytes are included.
- FIELDS: ',' increments field counter, saturating at 15. Other bytes go to the field selected by the counter: 1 time, 2 status ('A' sets shadow fix_valid), 3 lat, 4 'N', 5 lon, 6 'E'. Other fields are ignored.
- Capture: char written at index idx, idx increments. If a byte arrives at idx == MAX, the byte is dropped and the overflow flag is set.
- Empty field: length 0. A direction field with no character gives dir 0.
- '*' in FIELDS -> CS_HI. CR or LF in FIELDS -> csum_err pulse, IDLE.
- CS_HI/CS_LO: accept hex characters 0-9, A-F, a-f. A non-hex byte gives csum_err and IDLE.
- Commit decision is made on the CS_LO byte:
  - Commit requires field counter >= 6, no overflow, and (CHECK_CSUM = 0 or received byte == XOR).
  - On commit, all shadow values are copied to the outputs in the same edge, and new_fix = 1 on the next cycle only.
  - Otherwise csum_err = 1 for one cycle and outputs hold their previous values.
  - Both cases -> IDLE.
- new_fix and csum_err are cleared every cycle, independent of rx_valid. They are never asserted together.
- rx_valid low: state and data are frozen.

Decomposition:
- nmea_pkg holds:
  - ASCII constants: '$', ',', '*', CR, LF, 'A', 'N', 'E'.
  - FSM state enum.
  - Field-index constants: F_TIME = 1, F_STAT = 2, F_LAT = 3, F_NS = 4, F_LON = 5, F_EW = 6.
  - Function hex2nib, returning nibble plus valid bit.
- Sub-module nmea_field_buf #(MAX): capture buffer with idx, overflow flag, clear, and write strobe. Instantiated three times (time, lat, lon).

Test Plan:
- Nominal sentence "$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W*6A":
  - new_fix pulses once.
  - lat_chars "4807.038", lat_len = 8, lat_dir = 1.
  - lon_chars "01131.000", lon_len = 9, lon_dir = 1.
  - utc_chars "123519", utc_len = 6.
  - fix_valid = 1.
- Same sentence ending "*6B": csum_err pulses once, no new_fix, outputs unchanged. With CHECK_CSUM = 0 it commits instead.
- "$GNRMC..." with the correct checksum: commits when ACCEPT_GN = 1; ignored, with no pulses, when ACCEPT_GN = 0.
- Latitude field of 11 characters with LAT_MAX = 10: csum_err, no commit. Next valid sentence commits normally.
- '$' injected mid-latitude, followed by a complete valid sentence: exactly one new_fix, carrying the second sentence's data.
- Assert rst low mid-field: all outputs 0 immediately. A following valid sentence commits. Idle rx_valid gaps mid-sentence do not alter the result.

Source files
------------

// File: rtl/nmea_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nmea_pkg
//  Description : Shared constants, FSM state type and helpers for the NMEA
//                RMC sentence parser.
//  Revision    : 1.0  initial release
// ============================================================================
package nmea_pkg;

  // ASCII characters recognised by the parser
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_A      = 8'h41;
  localparam logic [7:0] CH_N      = 8'h4E;
  localparam logic [7:0] CH_E      = 8'h45;
  localparam logic [7:0] CH_G      = 8'h47;
  localparam logic [7:0] CH_P      = 8'h50;
  localparam logic [7:0] CH_R      = 8'h52;
  localparam logic [7:0] CH_M      = 8'h4D;
  localparam logic [7:0] CH_C      = 8'h43;

  // Parser states
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    TALK1  = 4'd1,
    TALK2  = 4'd2,
    TYP_R  = 4'd3,
    TYP_M  = 4'd4,
    TYP_C  = 4'd5,
    FIELDS = 4'd6,
    CS_HI  = 4'd7,
    CS_LO  = 4'd8
  } state_t;

  // Comma-delimited field positions inside an RMC sentence
  localparam logic [3:0] F_TIME = 4'd1;
  localparam logic [3:0] F_STAT = 4'd2;
  localparam logic [3:0] F_LAT  = 4'd3;
  localparam logic [3:0] F_NS   = 4'd4;
  localparam logic [3:0] F_LON  = 4'd5;
  localparam logic [3:0] F_EW   = 4'd6;

  // Hex character to nibble; bit 4 is the valid flag
  function automatic logic [4:0] hex2nib(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r = {1'b1, c[3:0] + 4'd9};
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nmea_field_buf.sv
`default_nettype none
// ============================================================================
//  Module      : nmea_field_buf
//  Description : Character capture buffer for one NMEA field. Stores up to
//                MAX characters, flags an overflow when more arrive.
//  Revision    : 1.0  initial release
// ============================================================================
module nmea_field_buf #(
  parameter int MAX = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         we,
  input  logic [7:0]                   din,
  output logic [8*MAX-1:0]             chars,
  output logic [$clog2(MAX+1)-1:0]     len,
  output logic                         ovf
);

  localparam int LW = $clog2(MAX+1);

  logic [LW-1:0] idx;

  assign len = idx;

  // Append characters at idx; a write with a full buffer only raises ovf
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chars <= '0;
      idx   <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      chars <= '0;
      idx   <= '0;
      ovf   <= 1'b0;
    end else if (we) begin
      if (idx == LW'(MAX)) begin
        ovf <= 1'b1;
      end else begin
        for (int i = 0; i < MAX; i++) begin
          if (idx == LW'(i)) begin
            chars[8*i +: 8] <= din;
          end
        end
        idx <= idx + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/nmea_rmc_parser.sv
`default_nettype none
// ============================================================================
//  Module      : nmea_rmc_parser
//  Description : Extracts UTC time, status, latitude and longitude from RMC
//                sentences, verifies the XOR checksum and commits all
//                outputs atomically with a one-cycle new_fix pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module nmea_rmc_parser
  import nmea_pkg::*;
#(
  parameter int LAT_MAX    = 10,
  parameter int LON_MAX    = 11,
  parameter int TIME_MAX   = 10,
  parameter int ACCEPT_GN  = 1,
  parameter int CHECK_CSUM = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_valid,
  output logic [8*LAT_MAX-1:0]           lat_chars,
  output logic [$clog2(LAT_MAX+1)-1:0]   lat_len,
  output logic                           lat_dir,
  output logic [8*LON_MAX-1:0]           lon_chars,
  output logic [$clog2(LON_MAX+1)-1:0]   lon_len,
  output logic                           lon_dir,
  output logic [8*TIME_MAX-1:0]          utc_chars,
  output logic [$clog2(TIME_MAX+1)-1:0]  utc_len,
  output logic                           fix_valid,
  output logic                           new_fix,
  output logic                           csum_err
);

  state_t state, state_nx;

  logic [7:0] xor_acc;
  logic [3:0] fld_cnt;
  logic [3:0] cs_hi;
  logic       sh_fix, sh_ns, sh_ew;

  logic       restart, xor_en, fld_inc, cs_hi_ld;
  logic       set_fix, set_ns, set_ew;
  logic       we_time, we_lat, we_lon;
  logic       commit, reject;

  logic [4:0] hex;
  logic       csum_ok;
  logic       any_ovf;

  logic [8*TIME_MAX-1:0]         time_buf_chars;
  logic [$clog2(TIME_MAX+1)-1:0] time_buf_len;
  logic                          time_buf_ovf;
  logic [8*LAT_MAX-1:0]          lat_buf_chars;
  logic [$clog2(LAT_MAX+1)-1:0]  lat_buf_len;
  logic                          lat_buf_ovf;
  logic [8*LON_MAX-1:0]          lon_buf_chars;
  logic [$clog2(LON_MAX+1)-1:0]  lon_buf_len;
  logic                          lon_buf_ovf;

  assign hex     = hex2nib(rx_data);
  assign csum_ok = (CHECK_CSUM == 0) || ({cs_hi, hex[3:0]} == xor_acc);
  assign any_ovf = time_buf_ovf | lat_buf_ovf | lon_buf_ovf;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state decode and per-byte action strobes
  always_comb begin
    state_nx = state;
    restart  = 1'b0;
    xor_en   = 1'b0;
    fld_inc  = 1'b0;
    cs_hi_ld = 1'b0;
    set_fix  = 1'b0;
    set_ns   = 1'b0;
    set_ew   = 1'b0;
    we_time  = 1'b0;
    we_lat   = 1'b0;
    we_lon   = 1'b0;
    commit   = 1'b0;
    reject   = 1'b0;
    if (rx_valid) begin
      if (rx_data == CH_DOLLAR) begin
        // A new sentence start always wins, discarding any partial one
        state_nx = TALK1;
        restart  = 1'b1;
      end else begin
        unique case (state)
          IDLE: ;
          TALK1: begin
            xor_en   = 1'b1;
            state_nx = (rx_data == CH_G) ? TALK2 : IDLE;
          end
          TALK2: begin
            xor_en   = 1'b1;
            state_nx = (rx_data == CH_P || (ACCEPT_GN != 0 && rx_data == CH_N)) ? TYP_R : IDLE;
          end
          TYP_R: begin
            xor_en   = 1'b1;
            state_nx = (rx_data == CH_R) ? TYP_M : IDLE;
          end
          TYP_M: begin
            xor_en   = 1'b1;
            state_nx = (rx_data == CH_M) ? TYP_C : IDLE;
          end
          TYP_C: begin
            xor_en   = 1'b1;
            state_nx = (rx_data == CH_C) ? FIELDS : IDLE;
          end
          FIELDS: begin
            if (rx_data == CH_STAR) begin
              state_nx = CS_HI;
            end else if (rx_data == CH_CR || rx_data == CH_LF) begin
              reject   = 1'b1;
              state_nx = IDLE;
            end else begin
              xor_en = 1'b1;
              if (rx_data == CH_COMMA) begin
                fld_inc = 1'b1;
              end else begin
                we_time = (fld_cnt == F_TIME);
                we_lat  = (fld_cnt == F_LAT);
                we_lon  = (fld_cnt == F_LON);
                set_fix = (fld_cnt == F_STAT) && (rx_data == CH_A);
                set_ns  = (fld_cnt == F_NS)   && (rx_data == CH_N);
                set_ew  = (fld_cnt == F_EW)   && (rx_data == CH_E);
              end
            end
          end
          CS_HI: begin
            if (hex[4]) begin
              cs_hi_ld = 1'b1;
              state_nx = CS_LO;
            end else begin
              reject   = 1'b1;
              state_nx = IDLE;
            end
          end
          CS_LO: begin
            state_nx = IDLE;
            if (hex[4] && fld_cnt >= F_EW && !any_ovf && csum_ok) commit = 1'b1;
            else                                                  reject = 1'b1;
          end
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  // Sentence-scope shadow state: checksum, field counter, status and directions
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xor_acc <= 8'd0;
      fld_cnt <= 4'd0;
      cs_hi   <= 4'd0;
      sh_fix  <= 1'b0;
      sh_ns   <= 1'b0;
      sh_ew   <= 1'b0;
    end else if (restart) begin
      xor_acc <= 8'd0;
      fld_cnt <= 4'd0;
      cs_hi   <= 4'd0;
      sh_fix  <= 1'b0;
      sh_ns   <= 1'b0;
      sh_ew   <= 1'b0;
    end else begin
      if (xor_en)                       xor_acc <= xor_acc ^ rx_data;
      if (fld_inc && fld_cnt != 4'd15)  fld_cnt <= fld_cnt + 4'd1;
      if (cs_hi_ld)                     cs_hi   <= hex[3:0];
      if (set_fix)                      sh_fix  <= 1'b1;
      if (set_ns)                       sh_ns   <= 1'b1;
      if (set_ew)                       sh_ew   <= 1'b1;
    end
  end

  // Output registers: copied as one set on commit; pulses last one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_chars <= '0;
      lat_len   <= '0;
      lat_dir   <= 1'b0;
      lon_chars <= '0;
      lon_len   <= '0;
      lon_dir   <= 1'b0;
      utc_chars <= '0;
      utc_len   <= '0;
      fix_valid <= 1'b0;
      new_fix   <= 1'b0;
      csum_err  <= 1'b0;
    end else begin
      new_fix  <= commit;
      csum_err <= reject;
      if (commit) begin
        lat_chars <= lat_buf_chars;
        lat_len   <= lat_buf_len;
        lat_dir   <= sh_ns;
        lon_chars <= lon_buf_chars;
        lon_len   <= lon_buf_len;
        lon_dir   <= sh_ew;
        utc_chars <= time_buf_chars;
        utc_len   <= time_buf_len;
        fix_valid <= sh_fix;
      end
    end
  end

  nmea_field_buf #(.MAX(TIME_MAX)) u_time_buf (
    .clk   (clk),
    .rst   (rst),
    .clr   (restart),
    .we    (we_time),
    .din   (rx_data),
    .chars (time_buf_chars),
    .len   (time_buf_len),
    .ovf   (time_buf_ovf)
  );

  nmea_field_buf #(.MAX(LAT_MAX)) u_lat_buf (
    .clk   (clk),
    .rst   (rst),
    .clr   (restart),
    .we    (we_lat),
    .din   (rx_data),
    .chars (lat_buf_chars),
    .len   (lat_buf_len),
    .ovf   (lat_buf_ovf)
  );

  nmea_field_buf #(.MAX(LON_MAX)) u_lon_buf (
    .clk   (clk),
    .rst   (rst),
    .clr   (restart),
    .we    (we_lon),
    .din   (rx_data),
    .chars (lon_buf_chars),
    .len   (lon_buf_len),
    .ovf   (lon_buf_ovf)
  );

endmodule
`default_nettype wire
